// File: rtl/psk_qam_mapper_if.sv
// Symbol-mapper handshake bundle: input symbol stream (bits/mode) and the
// output I/Q beat stream towards the pulse-shaping filter.
//   slave  : mapper side (consumes symbols, produces beats)
//   master : source/sink side (produces symbols, consumes beats)
interface psk_qam_mapper_if #(
  parameter int unsigned DATA_W = 12
);
  logic [3:0]               i_bits;
  logic [1:0]               i_mode;
  logic                     i_valid;
  logic                     o_ready_for_input;
  logic                     i_out_ready;
  logic                     o_valid;
  logic signed [DATA_W-1:0] o_I;
  logic signed [DATA_W-1:0] o_Q;
  logic                     o_first;

  modport slave (
    input  i_bits, i_mode, i_valid, i_out_ready,
    output o_ready_for_input, o_valid, o_I, o_Q, o_first
  );

  modport master (
    output i_bits, i_mode, i_valid, i_out_ready,
    input  o_ready_for_input, o_valid, o_I, o_Q, o_first
  );
endinterface

// File: rtl/psk_qam_mapper.sv
// BPSK / QPSK / Gray 16-QAM / null symbol mapper. Each accepted symbol is
// emitted for SPS output beats, either repeated or zero-stuffed after beat 0.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of psk_qam_mapper_if
//                in : i_bits, i_mode, i_valid, i_out_ready
//                out: o_ready_for_input (combinational), o_valid, o_I, o_Q,
//                     o_first (registered)
module psk_qam_mapper #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned AMP        = 1448,
  parameter int unsigned SPS        = 1,
  parameter int unsigned ZERO_STUFF = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  psk_qam_mapper_if.slave bus
);

  localparam int unsigned CNT_W     = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(SPS - 1);

  localparam int signed AMP_S = int'(AMP);
  localparam int signed LVL_S = int'(AMP / 3);

  localparam logic signed [DATA_W-1:0] P_AMP = DATA_W'(AMP_S);
  localparam logic signed [DATA_W-1:0] N_AMP = DATA_W'(-AMP_S);
  localparam logic signed [DATA_W-1:0] P_1L  = DATA_W'(LVL_S);
  localparam logic signed [DATA_W-1:0] N_1L  = DATA_W'(-LVL_S);
  localparam logic signed [DATA_W-1:0] P_3L  = DATA_W'(3 * LVL_S);
  localparam logic signed [DATA_W-1:0] N_3L  = DATA_W'(-3 * LVL_S);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic signed [DATA_W-1:0]  samp_i_q, samp_i_d;
  logic signed [DATA_W-1:0]  samp_q_q, samp_q_d;
  logic                      first_q, first_d;

  logic signed [DATA_W-1:0]  map_i, map_q;
  logic                      valid;
  logic                      last_beat;
  logic                      out_hs;
  logic                      ready_c;
  logic                      accept;

  // Gray 16-QAM axis level: 00 -> +3L, 01 -> +L, 11 -> -L, 10 -> -3L
  function automatic logic signed [DATA_W-1:0] qam_lvl(input logic [1:0] b);
    logic signed [DATA_W-1:0] lvl;
    unique case (b)
      2'b00:   lvl = P_3L;
      2'b01:   lvl = P_1L;
      2'b11:   lvl = N_1L;
      default: lvl = N_3L;
    endcase
    return lvl;
  endfunction

  // Constellation lookup of the symbol presented on the input side
  always_comb begin : map_symbol
    map_i = '0;
    map_q = '0;
    unique case (bus.i_mode)
      2'd0: map_i = bus.i_bits[0] ? N_AMP : P_AMP;
      2'd1: begin
        map_i = bus.i_bits[0] ? N_AMP : P_AMP;
        map_q = bus.i_bits[1] ? N_AMP : P_AMP;
      end
      2'd2: begin
        map_i = qam_lvl(bus.i_bits[1:0]);
        map_q = qam_lvl(bus.i_bits[3:2]);
      end
      default: ;
    endcase
  end

  assign valid     = (state_q == EMIT);
  assign last_beat = (beat_cnt_q == LAST_BEAT);
  assign out_hs    = valid && bus.i_out_ready;
  // Ready when empty, or when the final beat leaves this cycle (no bubble)
  assign ready_c   = rst_n && (!valid || (bus.i_out_ready && last_beat));
  assign accept    = bus.i_valid && ready_c;

  // Next-state and next-beat computation
  always_comb begin : next_state
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    samp_i_d   = samp_i_q;
    samp_q_d   = samp_q_q;
    first_d    = first_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = EMIT;
          beat_cnt_d = '0;
          samp_i_d   = map_i;
          samp_q_d   = map_q;
          first_d    = 1'b1;
        end
      end
      default: begin
        if (out_hs) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            if (accept) begin
              samp_i_d = map_i;
              samp_q_d = map_q;
              first_d  = 1'b1;
            end else begin
              state_d  = IDLE;
              samp_i_d = '0;
              samp_q_d = '0;
              first_d  = 1'b0;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            first_d    = 1'b0;
            if (ZERO_STUFF != 0) begin
              samp_i_d = '0;
              samp_q_d = '0;
            end
          end
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      samp_i_q   <= '0;
      samp_q_q   <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      samp_i_q   <= samp_i_d;
      samp_q_q   <= samp_q_d;
      first_q    <= first_d;
    end
  end

  assign bus.o_ready_for_input = ready_c;
  assign bus.o_valid           = valid;
  assign bus.o_I               = samp_i_q;
  assign bus.o_Q               = samp_q_q;
  assign bus.o_first           = first_q;

endmodule

// File: tb/tb_psk_qam_mapper.sv
// Self-checking bench for psk_qam_mapper: four instances cover SPS=1,
// SPS=4 repeat, SPS=4 zero-stuff and SPS=3 under random backpressure.
module tb_psk_qam_mapper;

  localparam int unsigned DW      = 12;
  localparam int          AMP     = 1448;
  localparam int          L       = AMP / 3;
  localparam int          RND_SPS = 3;
  localparam int          NV      = 27;

  logic clk;
  logic rst_n;

  int nerr = 0;
  int nchk = 0;

  psk_qam_mapper_if #(.DATA_W(DW)) bus_a ();
  psk_qam_mapper_if #(.DATA_W(DW)) bus_b ();
  psk_qam_mapper_if #(.DATA_W(DW)) bus_c ();
  psk_qam_mapper_if #(.DATA_W(DW)) bus_d ();

  psk_qam_mapper #(.DATA_W(DW), .AMP(AMP), .SPS(1), .ZERO_STUFF(0)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  psk_qam_mapper #(.DATA_W(DW), .AMP(AMP), .SPS(4), .ZERO_STUFF(0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  psk_qam_mapper #(.DATA_W(DW), .AMP(AMP), .SPS(4), .ZERO_STUFF(1)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c.slave));
  psk_qam_mapper #(.DATA_W(DW), .AMP(AMP), .SPS(RND_SPS), .ZERO_STUFF(0)) u_d (
    .clk(clk), .rst_n(rst_n), .bus(bus_d.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference mapping straight from the constellation definitions
  function automatic int gray_lvl(input logic [1:0] b);
    case (b)
      2'b00:   return 3;
      2'b01:   return 1;
      2'b11:   return -1;
      default: return -3;
    endcase
  endfunction

  task automatic ref_map(input logic [3:0] bits, input logic [1:0] mode,
                         output int ei, output int eq);
    ei = 0;
    eq = 0;
    case (mode)
      2'd0: ei = bits[0] ? -AMP : AMP;
      2'd1: begin
        ei = bits[0] ? -AMP : AMP;
        eq = bits[1] ? -AMP : AMP;
      end
      2'd2: begin
        ei = gray_lvl(bits[1:0]) * L;
        eq = gray_lvl(bits[3:2]) * L;
      end
      default: ;
    endcase
  endtask

  // Random-backpressure scoreboard: one entry per expected output beat
  int   sb_i[$];
  int   sb_q[$];
  bit   sb_f[$];
  bit   pend_d  = 1'b0;
  bit   stall_d = 1'b0;
  int   prev_i, prev_q, prev_f;
  int   acc_d   = 0;
  int   beats_d = 0;

  task automatic step_d(input bit allow_new);
    bit exp_v, exp_r, acc;
    int ei, eq;
    @(negedge clk);
    if (!pend_d) begin
      bus_d.i_valid = allow_new && ($urandom_range(0, 2) != 0);
      bus_d.i_bits  = 4'($urandom);
      bus_d.i_mode  = 2'($urandom);
    end
    bus_d.i_out_ready = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    exp_v = (sb_i.size() != 0);
    exp_r = !exp_v || (bus_d.i_out_ready && sb_i.size() == 1);
    check("rnd_valid", int'(bus_d.o_valid), int'(exp_v));
    check("rnd_ready", int'(bus_d.o_ready_for_input), int'(exp_r));
    if (stall_d) begin
      check("rnd_hold_i", int'(bus_d.o_I), prev_i);
      check("rnd_hold_q", int'(bus_d.o_Q), prev_q);
      check("rnd_hold_first", int'(bus_d.o_first), prev_f);
    end
    if (exp_v) begin
      check("rnd_i", int'(bus_d.o_I), sb_i[0]);
      check("rnd_q", int'(bus_d.o_Q), sb_q[0]);
      check("rnd_first", int'(bus_d.o_first), int'(sb_f[0]));
      if (bus_d.i_out_ready) begin
        void'(sb_i.pop_front());
        void'(sb_q.pop_front());
        void'(sb_f.pop_front());
      end
    end
    if (bus_d.o_valid && bus_d.i_out_ready) beats_d++;
    acc = bus_d.i_valid && exp_r;
    if (acc) begin
      ref_map(bus_d.i_bits, bus_d.i_mode, ei, eq);
      for (int b = 0; b < RND_SPS; b++) begin
        sb_i.push_back(ei);
        sb_q.push_back(eq);
        sb_f.push_back(b == 0);
      end
      acc_d++;
    end
    pend_d  = bus_d.i_valid && !acc;
    stall_d = exp_v && !bus_d.i_out_ready;
    prev_i  = int'(bus_d.o_I);
    prev_q  = int'(bus_d.o_Q);
    prev_f  = int'(bus_d.o_first);
  endtask

  typedef struct {
    logic [3:0] bits;
    logic [1:0] mode;
    int         ei;
    int         eq;
  } vec_t;

  initial begin
    vec_t        vecs [NV];
    logic [15:0] stream;
    int          qs_i [8];
    int          qs_q [8];
    int          lv   [4];
    logic [3:0]  v;
    int          n;
    int          guard;

    // Vector table: QPSK stream, all 16-QAM points, BPSK, null symbol
    stream = 16'b1110100101111000;
    qs_i   = '{1, 1, -1, -1, -1, 1, 1, -1};
    qs_q   = '{1, -1, -1, 1, 1, -1, -1, -1};
    lv     = '{1446, 482, -1446, -482};
    for (int k = 0; k < 8; k++) begin
      vecs[k].bits = {2'b00, stream[2*k +: 2]};
      vecs[k].mode = 2'd1;
      vecs[k].ei   = qs_i[k] * AMP;
      vecs[k].eq   = qs_q[k] * AMP;
    end
    for (int k = 0; k < 16; k++) begin
      v = 4'(k);
      vecs[8+k].bits = v;
      vecs[8+k].mode = 2'd2;
      vecs[8+k].ei   = lv[v[1:0]];
      vecs[8+k].eq   = lv[v[3:2]];
    end
    vecs[24] = '{bits: 4'b1111, mode: 2'd0, ei: -AMP, eq: 0};
    vecs[25] = '{bits: 4'b1110, mode: 2'd0, ei: AMP,  eq: 0};
    vecs[26] = '{bits: 4'b0110, mode: 2'd3, ei: 0,    eq: 0};

    bus_a.i_valid = 1'b0; bus_a.i_bits = '0; bus_a.i_mode = '0; bus_a.i_out_ready = 1'b1;
    bus_b.i_valid = 1'b0; bus_b.i_bits = '0; bus_b.i_mode = '0; bus_b.i_out_ready = 1'b1;
    bus_c.i_valid = 1'b0; bus_c.i_bits = '0; bus_c.i_mode = '0; bus_c.i_out_ready = 1'b1;
    bus_d.i_valid = 1'b0; bus_d.i_bits = '0; bus_d.i_mode = '0; bus_d.i_out_ready = 1'b1;

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    check("rst_valid", int'(bus_a.o_valid), 0);
    check("rst_i", int'(bus_a.o_I), 0);
    check("rst_first", int'(bus_b.o_first), 0);
    check("rst_ready_low", int'(bus_a.o_ready_for_input), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready_rel", int'(bus_a.o_ready_for_input), 1);

    // SPS=1 back-to-back table, one symbol per cycle
    for (int k = 0; k <= NV; k++) begin
      @(negedge clk);
      if (k < NV) begin
        bus_a.i_valid = 1'b1;
        bus_a.i_bits  = vecs[k].bits;
        bus_a.i_mode  = vecs[k].mode;
      end else begin
        bus_a.i_valid = 1'b0;
      end
      #1;
      check("tbl_ready", int'(bus_a.o_ready_for_input), 1);
      if (k > 0) begin
        check("tbl_valid", int'(bus_a.o_valid), 1);
        check("tbl_first", int'(bus_a.o_first), 1);
        check("tbl_i", int'(bus_a.o_I), vecs[k-1].ei);
        check("tbl_q", int'(bus_a.o_Q), vecs[k-1].eq);
      end
    end
    @(negedge clk); #1;
    check("tbl_idle", int'(bus_a.o_valid), 0);

    // SPS=4 upsampling, repeat (b) and zero-stuff (c), QPSK 2'b01
    @(negedge clk);
    bus_b.i_valid = 1'b1; bus_b.i_bits = 4'b0001; bus_b.i_mode = 2'd1;
    bus_c.i_valid = 1'b1; bus_c.i_bits = 4'b0001; bus_c.i_mode = 2'd1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus_b.i_valid = 1'b0;
      bus_c.i_valid = 1'b0;
      #1;
      check("up_rep_valid", int'(bus_b.o_valid), 1);
      check("up_rep_i", int'(bus_b.o_I), -AMP);
      check("up_rep_q", int'(bus_b.o_Q), AMP);
      check("up_rep_first", int'(bus_b.o_first), (b == 0) ? 1 : 0);
      check("up_rep_ready", int'(bus_b.o_ready_for_input), (b == 3) ? 1 : 0);
      check("up_zs_valid", int'(bus_c.o_valid), 1);
      check("up_zs_i", int'(bus_c.o_I), (b == 0) ? -AMP : 0);
      check("up_zs_q", int'(bus_c.o_Q), (b == 0) ? AMP : 0);
      check("up_zs_first", int'(bus_c.o_first), (b == 0) ? 1 : 0);
      check("up_zs_ready", int'(bus_c.o_ready_for_input), (b == 3) ? 1 : 0);
    end
    @(negedge clk); #1;
    check("up_rep_idle", int'(bus_b.o_valid), 0);
    check("up_zs_idle", int'(bus_c.o_valid), 0);

    // Reset at beat 2 of an SPS=4 symbol, then a fresh 16-QAM symbol
    @(negedge clk);
    bus_b.i_valid = 1'b1; bus_b.i_bits = 4'b0011; bus_b.i_mode = 2'd1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      bus_b.i_valid = 1'b0;
    end
    #1;
    check("mid_beat2_valid", int'(bus_b.o_valid), 1);
    check("mid_beat2_first", int'(bus_b.o_first), 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(bus_b.o_valid), 0);
    check("mid_rst_i", int'(bus_b.o_I), 0);
    check("mid_rst_q", int'(bus_b.o_Q), 0);
    check("mid_rst_ready", int'(bus_b.o_ready_for_input), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", int'(bus_b.o_ready_for_input), 1);
    bus_b.i_valid = 1'b1; bus_b.i_bits = 4'b1101; bus_b.i_mode = 2'd2;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus_b.i_valid = 1'b0;
      #1;
      check("mid_new_valid", int'(bus_b.o_valid), 1);
      check("mid_new_first", int'(bus_b.o_first), (b == 0) ? 1 : 0);
      check("mid_new_i", int'(bus_b.o_I), 482);
      check("mid_new_q", int'(bus_b.o_Q), -482);
    end
    @(negedge clk); #1;
    check("mid_new_idle", int'(bus_b.o_valid), 0);

    // SPS=3 random valid/backpressure against the scoreboard
    for (int c = 0; c < 800; c++) step_d(1'b1);
    guard = 0;
    while ((sb_i.size() != 0 || pend_d) && guard < 40) begin
      step_d(1'b0);
      guard++;
    end
    n = sb_i.size() + (pend_d ? 1 : 0);
    check("rnd_drained", n, 0);
    check("rnd_beat_total", beats_d, RND_SPS * acc_d);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/psk_qam_mapper.md
# psk_qam_mapper

Parametrised symbol mapper generalising the single-mode QPSK modulator: maps 1, 2 or 4 input bits per symbol to signed I/Q samples (BPSK, QPSK, Gray 16-QAM, selectable per symbol). Each symbol is held for SPS output beats, either repeated or zero-stuffed. It sits between the bit source and the pulse-shaping/interpolation filter, with valid/ready handshakes on both sides.

## Interface
- DATA_W, 12, width of signed o_I/o_Q (two's complement)
- AMP, 1448, QPSK/BPSK amplitude; 16-QAM level unit L = AMP/3 (integer division, elaboration time); 3·L and AMP must fit in DATA_W signed
- SPS, 1, output beats per symbol, ≥1
- ZERO_STUFF, 0, 0: repeat symbol SPS times; 1: symbol on beat 0, zeros on beats 1..SPS-1
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_bits  in  4  symbol bits, bit0 first
- i_mode  in  2  0 BPSK, 1 QPSK, 2 16-QAM, 3 null symbol
- i_valid  in  1  i_bits/i_mode valid
- o_ready_for_input  out  1  mapper accepts a symbol this cycle
- i_out_ready  in  1  downstream accepts current output beat
- o_valid  out  1  o_I/o_Q/o_first valid
- o_I  out  DATA_W  in-phase sample, signed
- o_Q  out  DATA_W  quadrature sample, signed
- o_first  out  1  high on beat 0 of each symbol

## Operation
- Accept: i_valid && o_ready_for_input; i_bits and i_mode sampled together on that edge.
- Mapping (bit value 0 → positive):
  - BPSK: I = bit0 ? -AMP : +AMP; Q = 0; bits[3:1] ignored.
  - QPSK: I from bit0, Q from bit1, ±AMP; bits[3:2] ignored.
  - 16-QAM: I from bits[1:0], Q from bits[3:2], Gray: 00→+3L, 01→+L, 11→-L, 10→-3L.
  - Mode 3: I = Q = 0; symbol still consumed and emitted for SPS beats.
- Beat counter beat_cnt 0..SPS-1; advances on each o_valid && i_out_ready; wraps to 0 after SPS-1.
- Beat output: beat 0 = mapped symbol, o_first = 1. Beats ≥1: same symbol if ZERO_STUFF=0, else I = Q = 0; o_first = 0.
- Two states: IDLE (o_valid = 0), EMIT (o_valid = 1).
  - IDLE → EMIT on accept.
  - EMIT → EMIT on final-beat handshake with simultaneous accept (back-to-back, no bubble).
  - EMIT → IDLE on final-beat handshake without accept.
- o_ready_for_input = rst_n && (!o_valid || (i_out_ready && beat_cnt == SPS-1)); combinational from i_out_ready, no other path.

## Timing
- Reset (asynchronous, any cycle, including mid-symbol): o_valid = 0, o_I = 0, o_Q = 0, o_first = 0, beat_cnt = 0, state IDLE. o_ready_for_input = 0 while rst_n low, 1 from the first cycle after release. In-flight symbol discarded.
- Latency: symbol accepted at edge N is presented on o_I/o_Q from edge N (registered), visible in cycle N+1.
- Throughput: one symbol per SPS cycles with i_out_ready held high; SPS = 1 gives one symbol per cycle.
- Backpressure: while o_valid && !i_out_ready, o_I/o_Q/o_first/beat_cnt hold and o_ready_for_input = 0.
- i_valid without ready: no state change; the source holds data (AXI-stream rules).
- No output beat is dropped or duplicated. Total handshaken beats = SPS × accepted symbols.

## Test plan
- Reset mid-symbol: SPS=4, assert rst_n low at beat 2 → o_valid = 0, o_I = o_Q = 0 the same cycle; after release, the next symbol starts at beat 0 with o_first = 1.
- QPSK stream, SPS=1, i_out_ready = 1: stream 16'b1110100101111000 taken LSB pairs first. Required outputs, (I,Q) in units of AMP=1448: (+,+), (+,-), (-,-), (-,+), (-,+), (+,-), (+,-), (-,-), one per cycle, no bubbles.
- 16-QAM, all 16 i_bits values → I,Q ∈ {+1446, +482, -482, -1446} per the Gray table. Example: i_bits = 4'b1101 gives I = +482, Q = -482.
- BPSK and mode 3, SPS=1: BPSK bit0 = 1 → I = -1448, Q = 0. Mode 3 → I = Q = 0, o_valid still asserted for the beat.
- Upsampling, SPS=4: with ZERO_STUFF=0, one QPSK symbol 2'b01 → four beats (-1448,+1448), o_first = 1,0,0,0. With ZERO_STUFF=1 → beats (-1448,+1448), (0,0), (0,0), (0,0). o_ready_for_input is high only in the final-beat cycle.
- Random backpressure, SPS=3, random i_valid and i_out_ready: outputs are stable whenever stalled, beat count = 3 × accepted symbols, symbol order matches a scoreboard, no bubble between symbols when both sides are ready.
